// File: rtl/fifo_pkg.sv
// Shared sizing helpers, read-mode constants and threshold sanity check for the sync FIFO.
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int fifo_clog2(input int n);
      return $clog2(n);
   endfunction

   // Level counts 0..depth inclusive, so it needs one bit more than the address.
   function automatic int lvl_width(input int depth);
      return fifo_clog2(depth) + 1;
   endfunction

   function automatic bit th_ok(input int th, input int depth);
      return (th > 0) && (th < depth);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
// Latency: write lands at the clock edge, read is combinational; no backpressure of its own.
module fifo_ram #(
   parameter int WIDTH   = 8,
   parameter int POINTER = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [POINTER-1:0] waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [POINTER-1:0] raddr,
   output logic [WIDTH-1:0]   rdata
);

   localparam int DEPTH = 1 << POINTER;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered level/status, sticky error flags, flush and std/FWFT read.
// Latency: 1 cycle push-to-visible; pushes refused when full (unless popping), pops refused when empty.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int POINTER   = 4,
   parameter int AFULL_TH  = (1 << POINTER) - 2,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = FIFO_STD
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               rd_en,
   output logic [WIDTH-1:0]   data_out,
   output logic               rd_valid,
   output logic               wr_full,
   output logic               rd_empty,
   output logic               almost_full,
   output logic               almost_empty,
   output logic [POINTER:0]   level,
   output logic               overflow,
   output logic               underflow
);

   localparam int DEPTH = 1 << POINTER;
   localparam int LW    = lvl_width(DEPTH);

   localparam logic [POINTER:0] LVL_ONE   = {{POINTER{1'b0}}, 1'b1};
   localparam logic [POINTER:0] AF_LVL    = AFULL_TH[POINTER:0];
   localparam logic [POINTER:0] AE_LVL    = AEMPTY_TH[POINTER:0];

   if (!th_ok(AFULL_TH, DEPTH) || !th_ok(AEMPTY_TH, DEPTH)) begin : g_bad_th
      $error("sync_fifo_ctrl: AFULL_TH/AEMPTY_TH must lie strictly between 0 and DEPTH");
   end
   if (LW != POINTER + 1) begin : g_bad_lw
      $error("sync_fifo_ctrl: level width inconsistent with POINTER");
   end
   if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
      $error("sync_fifo_ctrl: FWFT must be 0 or 1");
   end

   logic [POINTER:0]  wr_ptr, rd_ptr;
   logic [POINTER:0]  wr_ptr_nxt, rd_ptr_nxt, level_nxt;
   logic              push_ok, pop_ok;
   logic              ram_we;
   logic [WIDTH-1:0]  ram_rdata;
   logic [WIDTH-1:0]  dout_q;
   logic              rd_valid_q;

   always_comb begin
      pop_ok     = rd_en & ~rd_empty;
      push_ok    = wr_en & (~wr_full | pop_ok);
      wr_ptr_nxt = push_ok ? wr_ptr + LVL_ONE : wr_ptr;
      rd_ptr_nxt = pop_ok  ? rd_ptr + LVL_ONE : rd_ptr;
      level_nxt  = level;
      case ({push_ok, pop_ok})
         2'b10:   level_nxt = level + LVL_ONE;
         2'b01:   level_nxt = level - LVL_ONE;
         default: level_nxt = level;
      endcase
   end

   // Neither reset nor flush may commit a write into the array.
   assign ram_we = push_ok & reset_n & ~flush;

   fifo_ram #(
      .WIDTH   (WIDTH),
      .POINTER (POINTER)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr[POINTER-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr[POINTER-1:0]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         dout_q       <= '0;
         rd_valid_q   <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         wr_full      <= 1'b0;
         rd_empty     <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else if (flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         rd_valid_q   <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         wr_full      <= 1'b0;
         rd_empty     <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         level        <= level_nxt;
         rd_valid_q   <= pop_ok;
         // Pointer MSBs carry wrap parity: differing MSBs with equal address bits means full.
         wr_full      <= (wr_ptr_nxt[POINTER] != rd_ptr_nxt[POINTER]) &&
                         (wr_ptr_nxt[POINTER-1:0] == rd_ptr_nxt[POINTER-1:0]);
         rd_empty     <= (wr_ptr_nxt == rd_ptr_nxt);
         almost_full  <= (level_nxt >= AF_LVL);
         almost_empty <= (level_nxt <= AE_LVL);
         if (pop_ok) begin
            dout_q <= ram_rdata;
         end
         if (wr_en && !push_ok) begin
            overflow <= 1'b1;
         end
         if (rd_en && !pop_ok) begin
            underflow <= 1'b1;
         end
      end
   end

   // In FWFT the head word shows through directly; when empty the last popped word is held.
   always_comb begin
      if (FWFT == FIFO_FWFT) begin
         data_out = rd_empty ? dout_q : ram_rdata;
         rd_valid = ~rd_empty;
      end else begin
         data_out = dout_q;
         rd_valid = rd_valid_q;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: a standard-read instance and an FWFT instance share stimulus.
module tb_sync_fifo_ctrl;

   localparam int WIDTH   = 8;
   localparam int POINTER = 4;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               flush = 1'b0;
   logic               wr_en = 1'b0;
   logic [WIDTH-1:0]   data_in = '0;
   logic               rd_en = 1'b0;

   logic [WIDTH-1:0]   s_data_out, f_data_out;
   logic               s_rd_valid, f_rd_valid;
   logic               s_wr_full, f_wr_full;
   logic               s_rd_empty, f_rd_empty;
   logic               s_almost_full, f_almost_full;
   logic               s_almost_empty, f_almost_empty;
   logic [POINTER:0]   s_level, f_level;
   logic               s_overflow, f_overflow;
   logic               s_underflow, f_underflow;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(.WIDTH(WIDTH), .POINTER(POINTER), .FWFT(0)) u_std (
      .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(s_data_out), .rd_valid(s_rd_valid), .wr_full(s_wr_full),
      .rd_empty(s_rd_empty), .almost_full(s_almost_full), .almost_empty(s_almost_empty),
      .level(s_level), .overflow(s_overflow), .underflow(s_underflow)
   );

   sync_fifo_ctrl #(.WIDTH(WIDTH), .POINTER(POINTER), .FWFT(1)) u_fwft (
      .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(f_data_out), .rd_valid(f_rd_valid), .wr_full(f_wr_full),
      .rd_empty(f_rd_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
      .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
      step(); step();
      reset_n = 1'b1;
   endtask

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] exp_d;
   int               wr_tog, rd_tog;
   logic             wr_msb, rd_msb;
   bit               do_push, do_pop;

   initial begin
      // ---- reset state ----
      do_reset();
      chk("rst_level",   32'(s_level), 0);
      chk("rst_empty",   32'(s_rd_empty), 1);
      chk("rst_full",    32'(s_wr_full), 0);
      chk("rst_aempty",  32'(s_almost_empty), 1);
      chk("rst_afull",   32'(s_almost_full), 0);
      chk("rst_dout",    32'(s_data_out), 0);
      chk("rst_valid",   32'(s_rd_valid), 0);
      chk("rst_ovf",     32'(s_overflow), 0);
      chk("rst_unf",     32'(s_underflow), 0);

      // ---- fill 0x0A..0x19 ----
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; data_in = 8'(8'h0A + i);
         step();
         chk("fill_level",  32'(s_level), 32'(i + 1));
         chk("fill_afull",  32'(s_almost_full), 32'((i + 1) >= 14));
         chk("fill_aempty", 32'(s_almost_empty), 32'((i + 1) <= 2));
         chk("fill_full",   32'(s_wr_full), 32'((i + 1) == 16));
         chk("fill_empty",  32'(s_rd_empty), 0);
      end

      // ---- push+pop while full: head out, 0x55 to tail, no overflow ----
      wr_en = 1'b1; data_in = 8'h55; rd_en = 1'b1;
      step();
      chk("pp_full_level", 32'(s_level), 16);
      chk("pp_full_dout",  32'(s_data_out), 32'h0A);
      chk("pp_full_valid", 32'(s_rd_valid), 1);
      chk("pp_full_full",  32'(s_wr_full), 1);
      chk("pp_full_ovf",   32'(s_overflow), 0);

      // ---- 17th push rejected ----
      rd_en = 1'b0; data_in = 8'h99;
      step();
      chk("ovf_flag",  32'(s_overflow), 1);
      chk("ovf_level", 32'(s_level), 16);
      wr_en = 1'b0;

      // ---- drain: 0x0B..0x19 then 0x55 ----
      for (int i = 0; i < 16; i++) begin
         exp_d = (i < 15) ? 8'(8'h0B + i) : 8'h55;
         rd_en = 1'b1;
         step();
         chk("drain_dout",  32'(s_data_out), 32'(exp_d));
         chk("drain_valid", 32'(s_rd_valid), 1);
         chk("drain_level", 32'(s_level), 32'(15 - i));
      end
      chk("drain_empty", 32'(s_rd_empty), 1);
      rd_en = 1'b0;
      step();
      chk("idle_valid", 32'(s_rd_valid), 0);
      rd_en = 1'b1;
      step();
      chk("unf_flag",  32'(s_underflow), 1);
      chk("unf_hold",  32'(s_data_out), 32'h55);
      chk("unf_valid", 32'(s_rd_valid), 0);
      rd_en = 1'b0;

      // ---- push+pop while empty ----
      do_reset();
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h33;
      step();
      chk("pp_empty_level", 32'(s_level), 1);
      chk("pp_empty_unf",   32'(s_underflow), 1);
      chk("pp_empty_valid", 32'(s_rd_valid), 0);
      wr_en = 1'b0;
      step();
      chk("pp_empty_dout",  32'(s_data_out), 32'h33);
      chk("pp_empty_lvl0",  32'(s_level), 0);
      rd_en = 1'b0;

      // ---- wrap-around with a reference queue ----
      flush = 1'b1;
      step();
      flush = 1'b0;
      q.delete();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = 8'(8'h40 + i);
         q.push_back(data_in);
         step();
      end
      wr_tog = 0; rd_tog = 0;
      wr_msb = u_std.wr_ptr[POINTER]; rd_msb = u_std.rd_ptr[POINTER];
      for (int i = 0; i < 40; i++) begin
         do_push = (i % 8) != 4;
         do_pop  = (i % 8) != 0;
         wr_en = do_push; rd_en = do_pop; data_in = 8'(8'h45 + i);
         step();
         if (do_pop) begin
            exp_d = q.pop_front();
            chk("wrap_dout",  32'(s_data_out), 32'(exp_d));
            chk("wrap_valid", 32'(s_rd_valid), 1);
         end
         if (do_push) q.push_back(data_in);
         chk("wrap_level",  32'(s_level), 32'(q.size()));
         chk("wrap_aempty", 32'(s_almost_empty), 32'(q.size() <= 2));
         if (u_std.wr_ptr[POINTER] != wr_msb) wr_tog++;
         if (u_std.rd_ptr[POINTER] != rd_msb) rd_tog++;
         wr_msb = u_std.wr_ptr[POINTER]; rd_msb = u_std.rd_ptr[POINTER];
      end
      chk("wrap_wr_toggles", 32'(wr_tog >= 2), 1);
      chk("wrap_rd_toggles", 32'(rd_tog >= 2), 1);
      wr_en = 1'b0; rd_en = 1'b0;

      // ---- FWFT single word ----
      do_reset();
      chk("fwft_idle_valid", 32'(f_rd_valid), 0);
      wr_en = 1'b1; data_in = 8'hA5;
      step();
      wr_en = 1'b0;
      chk("fwft_dout",  32'(f_data_out), 32'hA5);
      chk("fwft_valid", 32'(f_rd_valid), 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("fwft_ack_valid", 32'(f_rd_valid), 0);
      chk("fwft_ack_empty", 32'(f_rd_empty), 1);

      // ---- flush mid-operation ----
      do_reset();
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; data_in = 8'(8'h80 + i);
         step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rd_en = 1'b1;
         step();
      end
      rd_en = 1'b0;
      chk("pre_flush_level", 32'(s_level), 7);
      chk("pre_flush_ovf",   32'(s_overflow), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_level", 32'(s_level), 0);
      chk("flush_empty", 32'(s_rd_empty), 1);
      chk("flush_ovf",   32'(s_overflow), 0);
      chk("flush_dout",  32'(s_data_out), 32'h88);

      // ---- reset wins over a concurrent push ----
      wr_en = 1'b1; data_in = 8'h61;
      step(); step();
      reset_n = 1'b0; data_in = 8'h77;
      step();
      reset_n = 1'b1; wr_en = 1'b0;
      chk("rstwr_level", 32'(s_level), 0);
      chk("rstwr_empty", 32'(s_rd_empty), 1);
      step();
      chk("rstwr_level2", 32'(s_level), 0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("rstwr_unf",  32'(s_underflow), 1);
      chk("rstwr_dout", 32'(s_data_out), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO with a registered status/level interface and explicit push/pop enables.
- Serves as the same-clock-domain buffer between producer and consumer stages, e.g. the stimulus source feeding a downstream datapath.
- Adds write/read enables, level count, programmable almost-full/almost-empty, sticky overflow/underflow, flush, and a standard/first-word-fall-through (FWFT) read mode.

Parameters:
- WIDTH, 8, data word width in bits.
- POINTER, 4, address bits; DEPTH = 1 << POINTER entries.
- AFULL_TH, DEPTH-2, almost_full asserts when level >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when level <= AEMPTY_TH.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of pointers, level and flags; memory contents untouched.
- wr_en  in  1  push request.
- data_in  in  WIDTH  push data.
- rd_en  in  1  pop request.
- data_out  out  WIDTH  read data.
- rd_valid  out  1  data_out holds a valid popped word (standard) or a valid head word (FWFT).
- wr_full  out  1  level == DEPTH.
- rd_empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_TH.
- almost_empty  out  1  level <= AEMPTY_TH.
- level  out  POINTER+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset: sampled only on a clk edge while reset_n = 0.
  - wr_pointer, rd_pointer, level and data_out go to 0.
  - rd_valid, overflow and underflow go to 0; wr_full = 0, rd_empty = 1, almost_empty = 1, almost_full = 0.
  - Reset has priority over flush. Flush has the same effect except data_out holds its value.
- Pointers: POINTER+1 bits in binary, so the MSB gives wrap parity. The RAM is indexed by [POINTER-1:0].
  - Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Both pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated from state before the edge:
  - push_ok = wr_en & (~wr_full | pop_ok).
  - pop_ok = rd_en & ~rd_empty.
  - Simultaneous push+pop while full: both accepted, level unchanged, wr_full stays 1.
  - Simultaneous push+pop while empty: push accepted, pop rejected, underflow set.
- Rejected requests: a rejected push sets overflow; a rejected pop sets underflow. Neither changes pointers. Both flags clear only on reset or flush.
- Level update: +1 on push only, −1 on pop only, unchanged otherwise. All status outputs are registered and consistent with level in the same cycle.
- Standard mode (FWFT=0):
  - A pop accepted at edge N loads mem[rd_ptr] into data_out at edge N.
  - rd_valid = 1 for exactly the cycle after each accepted pop.
  - data_out holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; rd_valid = ~rd_empty.
  - rd_en acts as an acknowledge.
  - Write-to-visible latency is 1 cycle: a push at edge N is visible after edge N when the FIFO was empty.
- Memory write: mem[wr_ptr] <= data_in on push_ok. Memory has no reset.
- Thresholds: AFULL_TH and AEMPTY_TH must satisfy 0 < TH < DEPTH. An out-of-range value is an elaboration error, enforced by a generate-time check.

Decomposition:
- Package fifo_pkg:
  - level/pointer width helper functions (clog2).
  - Mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
  - Threshold sanity-check function.
- Sub-module fifo_ram: a WIDTH×DEPTH register array with one synchronous write port and one asynchronous read port, instantiated once.
- Pointer, level, flag and mode logic stay in sync_fifo_ctrl.

Test Plan (WIDTH=8, POINTER=4, DEPTH=16, defaults unless noted):
- Reset/fill: after reset_n low for 2 cycles, push 0x0A..0x19 (16 words).
  - Level climbs 0→16; almost_full at 14; wr_full at 16; rd_empty=0 after the first push.
  - A 17th push sets overflow=1 and leaves level=16.
- Drain order, FWFT=0: from full, pop 16 words.
  - data_out = 0x0A..0x19 in order, each one cycle after its rd_en, with rd_valid pulses.
  - rd_empty=1 at level 0; an extra pop sets underflow=1 and data_out holds 0x19.
- Simultaneous push+pop:
  - At level 16: push 0x55 with pop → level stays 16; output is the head word; 0x55 lands at the tail; no overflow.
  - At level 0: push+pop → level 1; underflow=1.
- Wrap-around: 40 interleaved push/pop cycles with level kept between 3 and 10.
  - Every word is read back in order and both pointer MSBs toggle at least twice.
  - almost_empty tracks level <= 2 exactly.
- FWFT=1: a single push of 0xA5 into an empty FIFO.
  - data_out=0xA5 and rd_valid=1 the cycle after the push, without rd_en.
  - After rd_en: rd_valid=0, rd_empty=1.
- Flush and reset mid-operation:
  - With level 7 and overflow=1, assert flush → next cycle level=0, rd_empty=1, overflow=0.
  - Assert reset_n=0 together with wr_en=1 → no word is written and level=0.
